// File: rtl/mux_1_3_hls_deadlock_pkg.sv
// Shared definitions for the mux_1_3 deadlock-detection path.
//   state_e      : reporter FSM states (IDLE / COUNT / REPORT / HOLD)
//   RPT_*        : bit positions of the fields inside the 32-bit report word
package mux_1_3_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam int RPT_W        = 32;
    localparam int RPT_MASK_LSB = 0;
    localparam int RPT_SEQ_LSB  = 16;
    localparam int RPT_SEQ_W    = 16;

endpackage

// File: rtl/mux_1_3_hls_deadlock_reporter.sv
// Consumer end of the mux_1_3 deadlock-detection path.
// Qualifies a deadlock once `block` has been high for TIMEOUT consecutive
// sampled cycles, then emits exactly one report word per episode on an
// AXI-Stream master port and sets a sticky `deadlock` status flag.
//
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   block               : registered block flag from the deadlock monitor
//   axis_block_sigs     : per-channel block vector, sampled with `block`
//   clear               : single-cycle pulse clearing `deadlock`
//   report_tdata/tvalid : report stream (master), tready from the sink
//   deadlock            : sticky flag, set when a report is issued
module mux_1_3_hls_deadlock_reporter
    import mux_1_3_hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 4,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    output logic [RPT_W-1:0]    report_tdata,
    output logic                report_tvalid,
    input  logic                report_tready,
    output logic                deadlock
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                 state;
    state_e                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [NUM_AXIS-1:0]    mask;
    logic [NUM_AXIS-1:0]    mask_next;
    logic [NUM_AXIS-1:0]    mask_acc;
    logic [RPT_SEQ_W-1:0]   seq;
    logic [RPT_W-1:0]       rpt_word;
    logic                   enter_report;
    logic                   accept;

    // report_tvalid is high exactly while the FSM sits in REPORT
    assign accept = report_tvalid && report_tready;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (block) begin
                    state_next = (TIMEOUT == 1) ? REPORT : COUNT;
                end
            end
            COUNT: begin
                if (!block) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                // block falling here cannot withdraw valid; finish the handshake first
                if (accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!block) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        // OR of every vector sampled in this episode, including the current one
        mask_acc     = (state == IDLE) ? axis_block_sigs : (mask | axis_block_sigs);
        cnt_next     = (state == IDLE) ? CNT_W'(1) : (cnt + CNT_W'(1));
        mask_next    = mask_acc;
        enter_report = (state != REPORT) && (state_next == REPORT);

        // cnt and mask are only live while counting; this also stops cnt
        // from ever reaching TIMEOUT, so it cannot wrap
        if (state_next != COUNT) begin
            cnt_next  = '0;
            mask_next = '0;
        end

        rpt_word = '0;
        rpt_word[RPT_MASK_LSB +: NUM_AXIS] = mask_acc;
        rpt_word[RPT_SEQ_LSB +: RPT_SEQ_W] = seq;
    end

    // Registered outputs and counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            mask          <= '0;
            seq           <= '0;
            report_tdata  <= '0;
            report_tvalid <= 1'b0;
            deadlock      <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            mask          <= mask_next;
            report_tvalid <= (state_next == REPORT);
            if (enter_report) begin
                report_tdata <= rpt_word;
            end
            if (accept) begin
                seq <= seq + RPT_SEQ_W'(1);
            end
            // setting on REPORT entry takes priority over a coincident clear
            if (enter_report) begin
                deadlock <= 1'b1;
            end else if (clear) begin
                deadlock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_1_3_hls_deadlock_reporter.sv
// Directed testbench for mux_1_3_hls_deadlock_reporter.
// dut8 runs with TIMEOUT=8, dut1 with TIMEOUT=1; both share clock and reset.
module tb_mux_1_3_hls_deadlock_reporter;

    logic        clock;
    logic        reset_n;

    logic        block;
    logic [3:0]  sigs;
    logic        clear;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        deadlock;

    logic        block1;
    logic [3:0]  sigs1;
    logic        clear1;
    logic [31:0] tdata1;
    logic        tvalid1;
    logic        tready1;
    logic        deadlock1;

    int checks;
    int failures;

    mux_1_3_hls_deadlock_reporter #(.NUM_AXIS(4), .TIMEOUT(8), .CNT_W(16)) dut8 (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (block),
        .axis_block_sigs (sigs),
        .clear           (clear),
        .report_tdata    (tdata),
        .report_tvalid   (tvalid),
        .report_tready   (tready),
        .deadlock        (deadlock)
    );

    mux_1_3_hls_deadlock_reporter #(.NUM_AXIS(4), .TIMEOUT(1), .CNT_W(4)) dut1 (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (block1),
        .axis_block_sigs (sigs1),
        .clear           (clear1),
        .report_tdata    (tdata1),
        .report_tvalid   (tvalid1),
        .report_tready   (tready1),
        .deadlock        (deadlock1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        block = 1'b0; sigs = '0; clear = 1'b0; tready = 1'b0;
        block1 = 1'b0; sigs1 = '0; clear1 = 1'b0; tready1 = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Holds block high for 8 sampled edges (first vector on edge 0, rest
    // afterwards); leaves the bench in the cycle where the report is due.
    task automatic drive_episode(input logic [3:0] first_v, input logic [3:0] rest_v,
                                 input logic clr_last, output int early);
        early = 0;
        block = 1'b1;
        sigs  = first_v;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) sigs = rest_v;
            if (i == 7) clear = clr_last;
            tick();
            clear = 1'b0;
            if (i < 7 && tvalid) early++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        block = 1'b0; sigs = '0; clear = 1'b0; tready = 1'b0;
        block1 = 1'b0; sigs1 = '0; clear1 = 1'b0; tready1 = 1'b0;
        #2;
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0b expected 0", tvalid); end
        checks++; if (tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h expected 00000000", tdata); end
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL reset_deadlock: got %0b expected 0", deadlock); end
        checks++; if (tvalid1 !== 1'b0 || tdata1 !== 32'h0 || deadlock1 !== 1'b0) begin
            failures++; $display("FAIL reset_dut1: got v=%0b d=%h dl=%0b expected 0/00000000/0", tvalid1, tdata1, deadlock1);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_short_episode;
        int early;
        do_reset();
        tready = 1'b1;
        block = 1'b1; sigs = 4'h1;
        early = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (tvalid) early++;
        end
        block = 1'b0;
        tick();
        if (tvalid) early++;
        tick();
        checks++; if (early !== 0) begin failures++; $display("FAIL short_no_valid: got %0d valid cycles expected 0", early); end
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL short_tvalid: got %0b expected 0", tvalid); end
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL short_deadlock: got %0b expected 0", deadlock); end
        // a full-length episode afterwards must report at exact latency (FSM was back in IDLE)
        drive_episode(4'h2, 4'h2, 1'b0, early);
        checks++; if (early !== 0) begin failures++; $display("FAIL short_refill_early: got %0d expected 0", early); end
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0000_0002) begin
            failures++; $display("FAIL short_refill_report: got v=%0b d=%h expected 1/00000002", tvalid, tdata);
        end
        block = 1'b0;
        tick();
    endtask

    task automatic test_single_report;
        int early;
        int extra;
        do_reset();
        tready = 1'b1;
        drive_episode(4'h1, 4'h4, 1'b0, early);
        checks++; if (early !== 0) begin failures++; $display("FAIL single_early: got %0d expected 0", early); end
        checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL single_tvalid: got %0b expected 1", tvalid); end
        checks++; if (tdata !== 32'h0000_0005) begin failures++; $display("FAIL single_tdata: got %h expected 00000005", tdata); end
        checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL single_deadlock: got %0b expected 1", deadlock); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tvalid) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL single_extra_reports: got %0d extra valid cycles expected 0", extra); end
        block = 1'b0;
        tick();
        tick();
        checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL single_sticky: got %0b expected 1", deadlock); end
    endtask

    task automatic test_backpressure;
        int early;
        int stable;
        do_reset();
        tready = 1'b0;
        drive_episode(4'h1, 4'h4, 1'b0, early);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (tvalid === 1'b1 && tdata === 32'h0000_0005) stable++;
            tick();
        end
        checks++; if (stable !== 5) begin failures++; $display("FAIL bp_stable: got %0d stable cycles expected 5", stable); end
        tready = 1'b1;
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0000_0005) begin
            failures++; $display("FAIL bp_sixth: got v=%0b d=%h expected 1/00000005", tvalid, tdata);
        end
        tick();
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL bp_accepted: got %0b expected 0", tvalid); end
        block = 1'b0;
        tick();
        drive_episode(4'h2, 4'h2, 1'b0, early);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0001_0002) begin
            failures++; $display("FAIL bp_seq_next: got v=%0b d=%h expected 1/00010002", tvalid, tdata);
        end
        tick();
        block = 1'b0;
        tick();
    endtask

    task automatic test_seq_and_clear;
        int early;
        do_reset();
        tready = 1'b1;
        drive_episode(4'h8, 4'h8, 1'b0, early);
        checks++; if (tdata !== 32'h0000_0008) begin failures++; $display("FAIL seq_first: got %h expected 00000008", tdata); end
        tick();
        block = 1'b0;
        tick();
        drive_episode(4'h3, 4'h3, 1'b0, early);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0001_0003) begin
            failures++; $display("FAIL seq_second: got v=%0b d=%h expected 1/00010003", tvalid, tdata);
        end
        tick();
        block = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL clear_deadlock: got %0b expected 0", deadlock); end
        // clear on the REPORT-entry edge: the set wins
        drive_episode(4'h1, 4'h1, 1'b1, early);
        checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL clear_vs_set: got %0b expected 1", deadlock); end
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0002_0001) begin
            failures++; $display("FAIL seq_third: got v=%0b d=%h expected 1/00020001", tvalid, tdata);
        end
        // clear during an in-flight report leaves the report alone
        tready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL clear_in_report: got %0b expected 0", deadlock); end
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0002_0001) begin
            failures++; $display("FAIL clear_keeps_report: got v=%0b d=%h expected 1/00020001", tvalid, tdata);
        end
        tready = 1'b1;
        tick();
        block = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_report;
        int early;
        do_reset();
        tready = 1'b0;
        drive_episode(4'h6, 4'h6, 1'b0, early);
        checks++; if (tvalid !== 1'b1 || deadlock !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre: got v=%0b dl=%0b expected 1/1", tvalid, deadlock);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_tvalid: got %0b expected 0", tvalid); end
        checks++; if (tdata !== 32'h0) begin failures++; $display("FAIL rst_mid_tdata: got %h expected 00000000", tdata); end
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL rst_mid_deadlock: got %0b expected 0", deadlock); end
        #2;
        reset_n = 1'b1;
        block = 1'b0;
        tready = 1'b1;
        tick();
        drive_episode(4'h1, 4'h1, 1'b0, early);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0000_0001) begin
            failures++; $display("FAIL rst_mid_seq: got v=%0b d=%h expected 1/00000001", tvalid, tdata);
        end
        tick();
        block = 1'b0;
        tick();
    endtask

    task automatic test_timeout_one;
        int extra;
        do_reset();
        tready1 = 1'b1;
        block1 = 1'b1;
        sigs1 = 4'hA;
        #1;
        checks++; if (tvalid1 !== 1'b0) begin failures++; $display("FAIL t1_pre: got %0b expected 0", tvalid1); end
        tick();
        block1 = 1'b0;
        checks++; if (tvalid1 !== 1'b1 || tdata1 !== 32'h0000_000A || deadlock1 !== 1'b1) begin
            failures++; $display("FAIL t1_report: got v=%0b d=%h dl=%0b expected 1/0000000a/1", tvalid1, tdata1, deadlock1);
        end
        tick();
        checks++; if (tvalid1 !== 1'b0) begin failures++; $display("FAIL t1_accepted: got %0b expected 0", tvalid1); end
        tick();
        block1 = 1'b1;
        sigs1 = 4'h5;
        tick();
        checks++; if (tvalid1 !== 1'b1 || tdata1 !== 32'h0001_0005) begin
            failures++; $display("FAIL t1_second: got v=%0b d=%h expected 1/00010005", tvalid1, tdata1);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tvalid1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL t1_hold: got %0d extra valid cycles expected 0", extra); end
        block1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_short_episode();
        test_single_report();
        test_backpressure();
        test_seq_and_clear();
        test_reset_mid_report();
        test_timeout_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_1_3_hls_deadlock_reporter.md
# mux_1_3_hls_deadlock_reporter

Consumer end of the `mux_1_3` deadlock-detection path. It takes the registered `block` flag from the per-instance deadlock monitor, together with the raw AXI-Stream block vector. It qualifies a deadlock only when `block` has stayed high for a programmable number of consecutive cycles. It then emits one report word per deadlock episode on an AXI-Stream master port, and keeps a sticky `deadlock` flag for status readback.

## Interface
Parameters:
- `NUM_AXIS`, 4: width of the block vector; legal range 1..16.
- `TIMEOUT`, 1024: consecutive `block`-high cycles needed to qualify a deadlock; must be ≥1.
- `CNT_W`, 16: width of the consecutive-cycle counter; must satisfy `TIMEOUT` ≤ 2^`CNT_W`.

Ports:
- `clock`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `block`, in, 1: monitor output, already registered.
- `axis_block_sigs`, in, `NUM_AXIS`: per-channel block indications, sampled at the same time as `block`.
- `clear`, in, 1: synchronous, single-cycle pulse that clears `deadlock`.
- `report_tdata`, out, 32: report word.
- `report_tvalid`, out, 1: AXI-Stream valid.
- `report_tready`, in, 1: AXI-Stream ready.
- `deadlock`, out, 1: sticky flag, set when a deadlock is qualified.

## Operation
- The FSM has four states: IDLE, COUNT, REPORT, HOLD. Reset puts it in IDLE.
- IDLE: `cnt`=0, `mask`=0.
  - `block`=1 with `TIMEOUT`=1 → REPORT; `mask`=`axis_block_sigs`.
  - `block`=1 otherwise → COUNT; `cnt`=1, `mask`=`axis_block_sigs`.
- COUNT:
  - `block`=0 → IDLE; `cnt` and `mask` cleared.
  - `block`=1 → `cnt`+1 and `mask` |= `axis_block_sigs`.
  - When `block`=1 and `cnt`==`TIMEOUT`-1 → REPORT, and the final `mask` OR is included.
  - `cnt` never wraps, because COUNT is left before overflow.
- Entering REPORT: `report_tdata` is loaded and `deadlock` is set.
- REPORT: `report_tvalid`=1, and `report_tdata` stays stable until the handshake. On `report_tvalid`&&`report_tready`: `seq`+1 (16-bit, wraps 0xFFFF→0), then go to HOLD.
- HOLD: wait for `block`=0 (sampled) → IDLE. This gives exactly one report per episode, no matter how long `block` stays high.
- `block` dropping while in REPORT does not withdraw the report; AXI-Stream forbids dropping valid. The report completes, then HOLD sees `block`=0 and exits on the next cycle.
- Report word layout:
  - `[NUM_AXIS-1:0]`: `mask`, the OR of all sampled vectors over the episode.
  - `[15:NUM_AXIS]`: 0.
  - `[31:16]`: `seq` as it was before the increment.
- `clear`:
  - Clears `deadlock` on the next edge. It has no effect on the FSM, `seq`, or an in-flight report.
  - If `clear` coincides with the cycle that enters REPORT, the set wins and `deadlock`=1.
- Values after reset:
  - `report_tvalid`=0, `report_tdata`=0, `deadlock`=0.
  - `seq`=0, `cnt`=0, `mask`=0.
- Reset asserted mid-report drops `report_tvalid` immediately (asynchronous). The report is lost, and `seq` is not incremented.

## Timing
- `block` is high on the cycles sampled at edges 0..`TIMEOUT`-1. `report_tvalid` goes high after edge `TIMEOUT`-1, so it is visible in cycle `TIMEOUT`. Latency is therefore `TIMEOUT` cycles from the first sampled high to valid.
- `deadlock` rises in the same cycle as `report_tvalid`.
- If `report_tready` is held high, the report is accepted in its first valid cycle. The earliest next episode can then start 2 cycles after `block` falls: one cycle for HOLD to sample `block`=0, and one for IDLE.
- Within one cycle there is no combinational path from `report_tready` or `block` to any output. All outputs are registered.

## Structure
- Shared package `mux_1_3_hls_deadlock_pkg` holds:
  - the state enum (IDLE/COUNT/REPORT/HOLD);
  - the report field constants `RPT_MASK_LSB`=0, `RPT_SEQ_LSB`=16, `RPT_SEQ_W`=16.
- The block is a single flat module with no sub-module. The counter and FSM are small enough to stay inline.

## Test plan
1. `TIMEOUT`=8, `block` high for 7 cycles then low → no `report_tvalid`, `deadlock`=0, FSM back in IDLE.
2. `TIMEOUT`=8, `block` high for 20 cycles, vector 0b0001 then 0b0100, `report_tready`=1 → exactly one report in cycle 8 with `tdata`=0x0000_0005, then `deadlock`=1.
3. Same stimulus as 2 with `report_tready` low for 5 cycles → `tvalid` and `tdata` held stable for 5 cycles; accepted on the 6th cycle of valid; `seq` becomes 1.
4. Two separate episodes, then `clear` pulse → second report carries `seq`=1 in `[31:16]`; `deadlock` returns to 0 the cycle after `clear`. Then `clear` coinciding with REPORT entry → `deadlock` stays 1.
5. `reset_n` asserted while `report_tvalid`=1 → `tvalid`, `tdata` and `deadlock` are 0 asynchronously; the next report carries `seq`=0.
6. `TIMEOUT`=1, single-cycle `block` pulse → report in the following cycle; FSM is in HOLD and returns to IDLE once `block`=0 is sampled.
